// File: rtl/tinychip_pkg.sv
// Shared TinyChip control definitions.
//   state_e   : sequencer state encoding (also exported on the debug state port)
//   iclass_e  : instruction class derived from {bt, oc, fn}
//   OC_*, JUMP_*, HALT_* : instruction-field constants used by class decode
//   classify(): maps a raw {bt, oc, fn} triple to its instruction class
package tinychip_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu    = 3'd0,
        ClsBranch = 3'd1,
        ClsJump   = 3'd2,
        ClsLoad   = 3'd3,
        ClsStore  = 3'd4,
        ClsHalt   = 3'd5
    } iclass_e;

    localparam logic [2:0] OC_BEQ  = 3'b010;
    localparam logic [2:0] OC_BNE  = 3'b011;
    localparam logic [2:0] OC_LW   = 3'b100;
    localparam logic [2:0] OC_SW   = 3'b101;
    localparam logic [2:0] OC_SRL  = 3'b110;

    localparam logic [2:0] JUMP_OC = 3'b000;
    localparam logic [1:0] JUMP_FN = 2'b10;
    localparam logic [2:0] HALT_OC = 3'b111;
    localparam logic [1:0] HALT_FN = 2'b11;

    function automatic iclass_e classify(input logic       bt,
                                         input logic [2:0] oc,
                                         input logic [1:0] fn);
        iclass_e cls;
        cls = ClsAlu;
        if (bt) begin
            unique case (oc)
                OC_BEQ, OC_BNE: cls = ClsBranch;
                OC_LW:          cls = ClsLoad;
                OC_SW:          cls = ClsStore;
                OC_SRL:         cls = ClsAlu;
                default:        cls = ClsAlu;
            endcase
        end else begin
            if (oc == JUMP_OC && fn == JUMP_FN) begin
                cls = ClsJump;
            end else if (oc == HALT_OC && fn == HALT_FN) begin
                cls = ClsHalt;
            end
        end
        return cls;
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the TinyChip core. Walks each instruction
// through FETCH, DECODE, EXEC, MEM, WB and owns the PC, register-file, ALU
// operand-select and data-memory enables.
//
// Parameters:
//   MEM_LATENCY : cycles mem_read/mem_write are held in MEM (1..7)
//   CNT_W       : width of the retired-instruction counter
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   start             : leave IDLE (sampled only in IDLE)
//   bt, oc, fn        : decoder fields, captured in DECODE
//   eq                : comparator result, sampled only in EXEC
//   ir_load .. mem_write : datapath enables
//   busy, halted      : status
//   state_o           : current state encoding (debug)
//   retired           : saturating count of retired instructions
module instr_sequencer
    import tinychip_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bt,
    input  logic [2:0]       oc,
    input  logic [1:0]       fn,
    input  logic             eq,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_write,
    output logic             alu_src_imm,
    output logic             rf_write,
    output logic             wb_sel,
    output logic             mem_read,
    output logic             mem_write,
    output logic             busy,
    output logic             halted,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    // Counter value loaded on MEM entry; MEM ends on the cycle it reads zero.
    localparam logic [2:0] MemLast = 3'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] RetOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             bt_q;
    logic [2:0]       oc_q;
    logic [1:0]       fn_q;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] retired_q;

    iclass_e cls_q;
    logic    br_taken;

    // Later states see only the copy captured in DECODE, never the live fields.
    assign cls_q    = classify(bt_q, oc_q, fn_q);
    assign br_taken = (oc_q == OC_BEQ) ? eq : ~eq;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            bt_q      <= 1'b0;
            oc_q      <= 3'b000;
            fn_q      <= 2'b00;
            cnt_q     <= 3'b000;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StDecode) begin
                bt_q <= bt;
                oc_q <= oc;
                fn_q <= fn;
            end
            if ((pc_inc || pc_write) && (retired_q != '1)) begin
                retired_q <= retired_q + RetOne;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_write    = 1'b0;
        alu_src_imm = 1'b0;
        rf_write    = 1'b0;
        wb_sel      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        halted      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                ir_load = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                // Halt check uses the live fields: they are being captured this cycle.
                state_d = (classify(bt, oc, fn) == ClsHalt) ? StHalt : StExec;
            end
            StExec: begin
                alu_src_imm = bt_q;
                case (cls_q)
                    ClsBranch: begin
                        pc_write = br_taken;
                        pc_inc   = ~br_taken;
                        state_d  = StFetch;
                    end
                    ClsJump: begin
                        pc_write = 1'b1;
                        state_d  = StFetch;
                    end
                    ClsLoad, ClsStore: begin
                        cnt_d   = MemLast;
                        state_d = StMem;
                    end
                    default: begin
                        state_d = StWb;
                    end
                endcase
            end
            StMem: begin
                mem_read  = (cls_q == ClsLoad);
                mem_write = (cls_q == ClsStore);
                if (cnt_q == 3'b000) begin
                    if (cls_q == ClsStore) begin
                        pc_inc  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StWb: begin
                alu_src_imm = bt_q;
                rf_write    = 1'b1;
                wb_sel      = (cls_q == ClsLoad);
                pc_inc      = 1'b1;
                state_d     = StFetch;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy    = (state_q != StIdle) && (state_q != StHalt);
    assign state_o = state_q;
    assign retired = retired_q;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control FSM for the TinyChip core. It steps each 9-bit instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the enables for the program counter, register file, ALU operand select and data memory. It sits between `control_decoder` and the datapath blocks (`program_counter`, `register_file`, `alu_core`, `data_memory`), replacing ad-hoc per-clock control with one sequenced owner of those resources.

## Interface
- `MEM_LATENCY`, 1: cycles `mem_read`/`mem_write` are held in MEM; legal range 1–7.
- `CNT_W`, 16: width of the retired-instruction counter.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; one clock; dominates all other inputs
- `start`  in  1  leave IDLE; ignored in every other state
- `bt`  in  1  decoder bit_type (1 = immediate form)
- `oc`  in  3  decoder opcode
- `fn`  in  2  decoder funct
- `eq`  in  1  comparator result, data1 == immediate
- `ir_load`  out  1  latch instruction register
- `pc_inc`  out  1  PC ← PC+1
- `pc_write`  out  1  PC ← jump/branch target
- `alu_src_imm`  out  1  ALU operand2 = {imm, fn} when 1, data2 when 0
- `rf_write`  out  1  register-file write enable
- `wb_sel`  out  1  write-back source: 0 ALU, 1 memory
- `mem_read`  out  1  data-memory read enable
- `mem_write`  out  1  data-memory write enable
- `busy`  out  1  high in every state except IDLE and HALT
- `halted`  out  1  high in HALT
- `state_o`  out  3  current state encoding (debug)
- `retired`  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: `start` → FETCH.
- FETCH: `ir_load`=1 for one cycle → DECODE.
- DECODE: capture `bt`/`oc`/`fn` into internal regs. Every later state uses the captured copy only. Halt encoding (bt=0, oc=3'b111, fn=2'b11) → HALT; all other encodings → EXEC.
- EXEC, by captured class:
  - Branch, bt=1, oc=3'b010 (beq) or 3'b011 (bne): taken when eq (beq) or !eq (bne). Taken → `pc_write`=1; not taken → `pc_inc`=1. Next state FETCH.
  - Jump, bt=0, oc=3'b000, fn=2'b10: `pc_write`=1 → FETCH.
  - lw (bt=1, oc=3'b100) or sw (bt=1, oc=3'b101) → MEM.
  - All others (ALU/srl, either form) → WB.
  - `alu_src_imm` = captured bt throughout EXEC and WB.
- MEM: `mem_read` (lw) or `mem_write` (sw) held for exactly MEM_LATENCY cycles, timed by an internal down-counter.
  - sw, last cycle: `pc_inc`=1 → FETCH.
  - lw, last cycle → WB.
- WB: `rf_write`=1, `wb_sel`=1 for lw else 0, `pc_inc`=1 → FETCH.
- HALT: `halted`=1, all enables 0; held until `reset`.
- `retired` increments on every cycle with `pc_inc` or `pc_write` set and saturates at all-ones. Entering HALT does not count.
- `pc_inc` and `pc_write` are never high in the same cycle. `mem_read` and `mem_write` are never high in the same cycle.

## Timing
- Outputs are Moore: decoded from the registered state plus captured fields. No input-to-output combinational path, except `eq` → `pc_write`/`pc_inc` in EXEC.
- Reset: state IDLE, all 1-bit outputs 0, `state_o`=0, `retired`=0, captured fields 0, MEM counter 0.
- Cycles per instruction, FETCH through retire:
  - branch/jump: 3
  - ALU: 4
  - sw: 3+MEM_LATENCY
  - lw: 4+MEM_LATENCY
- `start` is sampled only in IDLE. `start` held high continuously causes no re-entry.
- `eq` is sampled only in EXEC.
- Reset in any state, including mid-MEM with `mem_write` high: next cycle is IDLE with all enables low. No partial write is extended.

## Structure
- `tinychip_pkg` holds:
  - state enum with explicit 3-bit encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6
  - opcode localparams OC_BEQ, OC_BNE, OC_LW, OC_SW, OC_SRL
  - JUMP_FN and the halt encoding constants
  - instruction class enum (ALU, BRANCH, JUMP, LOAD, STORE, HALT)
- Single module, no sub-modules. The MEM wait counter and class decode are inline.

## Test plan
- Reset then `start`=1 one cycle, addi (bt=1, oc=3'b000) → `ir_load` at cycle 1, `rf_write`=1, `wb_sel`=0, `pc_inc`=1 at cycle 4; `retired`=1.
- beq with eq=1, then beq with eq=0 → first: `pc_write`=1, `pc_inc`=0 in EXEC; second: `pc_inc`=1, `pc_write`=0; `retired`=2.
- MEM_LATENCY=3, lw → `mem_read` high exactly 3 cycles, then WB with `wb_sel`=1, `rf_write`=1; total 7 cycles.
- sw with `reset` asserted in its 2nd MEM cycle → next cycle IDLE, `mem_write`=0, `retired` unchanged at 0.
- Halt encoding (bt=0, oc=3'b111, fn=2'b11) → HALT after DECODE; `halted`=1, `busy`=0; `start` pulses ignored for 10 cycles.
- Preload `retired` near saturation with CNT_W=4, run 17 ALU instructions → `retired` holds at 4'hF.
